debug_msg_arbiter: RTL and testbench

DEBUG_MSG_ARBITER -- requirements
Module: debug_msg_arbiter

---
 rtl/debug_pkg.sv | 26 ++
 rtl/rr_picker.sv | 41 ++++
 rtl/debug_msg_arbiter.sv | 174 +++++++++++++++++
 tb/tb_debug_msg_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug message arbiter.
// Provides the byte width, the arbiter state encoding, the largest payload
// a single message may carry, and a helper that turns a requested payload
// length into the message length (command byte included).
package debug_pkg;

  localparam int BYTE_W = 8;

  // Longest payload a message may carry; a request of 255 is clamped to this.
  localparam logic [BYTE_W-1:0] MAX_PAYLOAD = 8'd254;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Message length = payload + command byte, saturating at MAX_PAYLOAD + 1.
  function automatic logic [BYTE_W-1:0] msg_len_of(input logic [BYTE_W-1:0] req_len);
    if (req_len > MAX_PAYLOAD) begin
      return MAX_PAYLOAD + 8'd1;
    end
    return req_len + 8'd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection.
// Ports:
//   req_valid  in  N     : per-requester pending flag
//   start_idx  in  IdxW  : index with highest priority this cycle
//   any_valid  out 1     : at least one requester is pending
//   win_idx    out IdxW  : first pending index at or after start_idx (wrapping)
module rr_picker #(
  parameter int N    = 4,
  parameter int IdxW = 2
) (
  input  logic [N-1:0]    req_valid,
  input  logic [IdxW-1:0] start_idx,
  output logic            any_valid,
  output logic [IdxW-1:0] win_idx
);

  logic [IdxW:0]   cand_sum [N];
  logic [IdxW-1:0] cand_idx [N];

  // cand_idx[gi] is the requester examined at priority position gi.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand_sum[gi] = {1'b0, start_idx} + (IdxW+1)'(gi);
    assign cand_idx[gi] = (cand_sum[gi] >= (IdxW+1)'(N)) ?
                          IdxW'(cand_sum[gi] - (IdxW+1)'(N)) :
                          IdxW'(cand_sum[gi]);
  end

  assign any_valid = |req_valid;

  // Walk from lowest priority to highest so the highest-priority hit is the
  // last assignment and therefore the one that sticks.
  always_comb begin
    win_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_valid[cand_idx[i]]) begin
        win_idx = cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/debug_msg_arbiter.sv
// Round-robin arbiter feeding one debug message port from several requesters.
// A granted requester's command byte is offered first, followed by its payload
// bytes as the debug port consumes them (msgTrigger). After each message the
// port is held idle for GapCycles cycles before the next grant.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/cmd/len   : per-requester request, command byte, payload length
//   pay_data            : per-requester current payload byte
//   grant               : one-hot owner of the message port
//   pay_pop / done      : per-requester byte-taken / message-finished pulses
//   len_err             : pulse when a length of 255 was clamped
//   msg / msgLen        : byte offered and bytes remaining (0 = idle)
//   msgTrigger          : debug port consumed the current byte
module debug_msg_arbiter
  import debug_pkg::*;
#(
  parameter int ReqCount  = 4,
  parameter int GapCycles = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ReqCount-1:0]        req_valid,
  input  logic [8*ReqCount-1:0]      req_cmd,
  input  logic [8*ReqCount-1:0]      req_len,
  input  logic [8*ReqCount-1:0]      pay_data,
  output logic [ReqCount-1:0]        grant,
  output logic [ReqCount-1:0]        pay_pop,
  output logic [ReqCount-1:0]        done,
  output logic                       len_err,
  output logic [7:0]                 msg,
  output logic [7:0]                 msgLen,
  input  logic                       msgTrigger
);

  localparam int IdxW = (ReqCount > 1) ? $clog2(ReqCount) : 1;
  localparam int GapW = $clog2(GapCycles + 1);

  state_e              state_q,     state_d;
  logic [BYTE_W-1:0]   msg_q,       msg_d;
  logic [BYTE_W-1:0]   msg_len_q,   msg_len_d;
  logic [ReqCount-1:0] grant_q,     grant_d;
  logic [ReqCount-1:0] pay_pop_q,   pay_pop_d;
  logic [ReqCount-1:0] done_q,      done_d;
  logic                len_err_q,   len_err_d;
  logic [IdxW-1:0]     gidx_q,      gidx_d;
  logic [IdxW-1:0]     ptr_q,       ptr_d;
  logic                started_q,   started_d;
  logic [GapW-1:0]     gap_cnt_q,   gap_cnt_d;

  logic [IdxW-1:0]     start_idx;
  logic [IdxW-1:0]     win_idx;
  logic                any_valid;
  logic [BYTE_W-1:0]   win_cmd;
  logic [BYTE_W-1:0]   win_len;
  logic [BYTE_W-1:0]   cur_pay;

  // ptr_q holds the last winner; until the first grant after reset the search
  // starts at index 0 instead of the one after the pointer.
  always_comb begin
    start_idx = '0;
    if (started_q && (ptr_q != IdxW'(ReqCount - 1))) begin
      start_idx = ptr_q + 1'b1;
    end
  end

  rr_picker #(
    .N    (ReqCount),
    .IdxW (IdxW)
  ) u_rr_picker (
    .req_valid (req_valid),
    .start_idx (start_idx),
    .any_valid (any_valid),
    .win_idx   (win_idx)
  );

  assign win_cmd = req_cmd [int'(win_idx)*BYTE_W +: BYTE_W];
  assign win_len = req_len [int'(win_idx)*BYTE_W +: BYTE_W];
  assign cur_pay = pay_data[int'(gidx_q)*BYTE_W +: BYTE_W];

  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    msg_len_d = msg_len_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    started_d = started_q;
    gap_cnt_d = gap_cnt_q;
    pay_pop_d = '0;
    done_d    = '0;
    len_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = win_idx;
          ptr_d            = win_idx;
          started_d        = 1'b1;
          msg_d            = win_cmd;
          msg_len_d        = msg_len_of(win_len);
          len_err_d        = (win_len > MAX_PAYLOAD);
          state_d          = ST_SEND;
        end
      end

      ST_SEND: begin
        if (msgTrigger) begin
          if (msg_len_q > 8'd1) begin
            msg_d             = cur_pay;
            msg_len_d         = msg_len_q - 8'd1;
            pay_pop_d[gidx_q] = 1'b1;
          end else begin
            // Last byte consumed: release the port and start the idle gap.
            msg_d          = '0;
            msg_len_d      = '0;
            grant_d        = '0;
            done_d[gidx_q] = 1'b1;
            gap_cnt_d      = '0;
            state_d        = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GapW'(GapCycles - 1)) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      msg_q     <= '0;
      msg_len_q <= '0;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      started_q <= 1'b0;
      gap_cnt_q <= '0;
      pay_pop_q <= '0;
      done_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      msg_len_q <= msg_len_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      started_q <= started_d;
      gap_cnt_q <= gap_cnt_d;
      pay_pop_q <= pay_pop_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
    end
  end

  assign grant   = grant_q;
  assign pay_pop = pay_pop_q;
  assign done    = done_q;
  assign len_err = len_err_q;
  assign msg     = msg_q;
  assign msgLen  = msg_len_q;

endmodule

// File: tb/tb_debug_msg_arbiter.sv
// Self-checking bench for debug_msg_arbiter (4 requesters, gap of 2 cycles).
// Expected messages are pushed to a scoreboard when requests are raised and
// popped when the arbiter grants; payload bytes come from a bench-side model.
module tb_debug_msg_arbiter;

  localparam int N   = 4;
  localparam int GAP = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_cmd;
  logic [8*N-1:0]  req_len;
  logic [8*N-1:0]  pay_data;
  logic [N-1:0]    grant;
  logic [N-1:0]    pay_pop;
  logic [N-1:0]    done;
  logic            len_err;
  logic [7:0]      msg;
  logic [7:0]      msgLen;
  logic            msgTrigger;

  typedef struct {
    int         r;
    logic [7:0] cmd;
    int         len;
  } exp_msg_t;

  exp_msg_t sb_q[$];

  int  cmd_a    [N];
  int  len_a    [N];
  int  pidx     [N];
  bit  reload_a [N];
  int  pop_total;
  int  n_checks;
  int  n_fail;

  debug_msg_arbiter #(
    .ReqCount  (N),
    .GapCycles (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_cmd    (req_cmd),
    .req_len    (req_len),
    .pay_data   (pay_data),
    .grant      (grant),
    .pay_pop    (pay_pop),
    .done       (done),
    .len_err    (len_err),
    .msg        (msg),
    .msgLen     (msgLen),
    .msgTrigger (msgTrigger)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_of(input int r, input int i);
    return 8'((r * 37 + i * 13 + 5) % 256);
  endfunction

  always_comb begin
    req_cmd  = '0;
    req_len  = '0;
    pay_data = '0;
    for (int r = 0; r < N; r++) begin
      req_cmd [r*8 +: 8] = 8'(cmd_a[r]);
      req_len [r*8 +: 8] = 8'(len_a[r]);
      pay_data[r*8 +: 8] = byte_of(r, pidx[r]);
    end
  end

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance one clock, sample 1 ns after the edge and update requester models.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) begin
      if (pay_pop[r]) begin
        pidx[r]++;
        pop_total++;
      end
      if (done[r]) begin
        pidx[r] = 0;
        if (!reload_a[r]) req_valid[r] = 1'b0;
      end
    end
  endtask

  task automatic setup_req(input int r, input int cmd, input int len, input bit reload, input bit push);
    cmd_a[r]     = cmd;
    len_a[r]     = len;
    reload_a[r]  = reload;
    req_valid[r] = 1'b1;
    if (push) sb_q.push_back('{r, 8'(cmd), len});
  endtask

  task automatic serve_one();
    exp_msg_t e;
    int w;
    int exp_len;
    int pops_before;
    w = 0;
    while (grant == '0 && w < 60) begin
      tick();
      w++;
    end
    if (grant == '0) begin
      check_eq("grant_timeout", 0, 1);
      return;
    end
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    exp_len = (e.len > 254) ? 255 : e.len + 1;
    check_eq("grant", grant, 1 << e.r);
    check_eq("cmd_msg", msg, e.cmd);
    check_eq("grant_msglen", msgLen, exp_len);
    check_eq("len_err", len_err, (e.len == 255) ? 1 : 0);
    pops_before = pop_total;
    for (int k = 1; k <= exp_len; k++) begin
      if (k % 3 == 2) begin
        tick();
        check_eq("hold_msglen", msgLen, exp_len - k + 1);
      end
      msgTrigger = 1'b1;
      tick();
      msgTrigger = 1'b0;
      if (k < exp_len) begin
        check_eq("pay_byte", msg, byte_of(e.r, k - 1));
        check_eq("pop_msglen", msgLen, exp_len - k);
        check_eq("pop_pulse", pay_pop, 1 << e.r);
      end else begin
        check_eq("end_msglen", msgLen, 0);
        check_eq("end_msg", msg, 0);
        check_eq("end_grant", grant, 0);
        check_eq("end_done", done, 1 << e.r);
        check_eq("end_pop", pay_pop, 0);
      end
    end
    check_eq("pop_count", pop_total - pops_before, exp_len - 1);
    // Triggers during the gap must be ignored and no grant may appear.
    for (int k = 0; k < GAP; k++) begin
      msgTrigger = 1'b1;
      tick();
      msgTrigger = 1'b0;
      check_eq("gap_msglen", msgLen, 0);
      check_eq("gap_grant", grant, 0);
      check_eq("gap_pop", pay_pop, 0);
    end
    $display("msg req%0d cmd=%02h len=%0d pops=%0d", e.r, e.cmd, e.len, pop_total - pops_before);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_msg_t e;
    n_checks   = 0;
    n_fail     = 0;
    pop_total  = 0;
    rst        = 1'b1;
    msgTrigger = 1'b0;
    req_valid  = '0;
    for (int r = 0; r < N; r++) begin
      cmd_a[r] = 0; len_a[r] = 0; pidx[r] = 0; reload_a[r] = 1'b0;
    end
    tick();
    tick();
    check_eq("rst_msg", msg, 0);
    check_eq("rst_msglen", msgLen, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_pop", pay_pop, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_len_err", len_err, 0);
    rst = 1'b0;
    tick();

    // Single message from requester 0.
    setup_req(0, 8'h81, 3, 1'b0, 1'b1);
    serve_one();

    // Trigger in IDLE with nothing pending.
    tick();
    msgTrigger = 1'b1;
    tick();
    msgTrigger = 1'b0;
    check_eq("idle_trig_msglen", msgLen, 0);
    check_eq("idle_trig_grant", grant, 0);
    check_eq("idle_trig_pop", pay_pop, 0);
    check_eq("idle_trig_done", done, 0);
    $display("idle trigger filtered msgLen=%0d", msgLen);

    // Fairness: all four requesting continuously.
    setup_req(0, 8'h10, 1, 1'b1, 1'b0);
    setup_req(1, 8'h11, 2, 1'b1, 1'b0);
    setup_req(2, 8'h12, 0, 1'b1, 1'b0);
    setup_req(3, 8'h13, 1, 1'b1, 1'b0);
    sb_q.push_back('{1, 8'h11, 2});
    sb_q.push_back('{2, 8'h12, 0});
    sb_q.push_back('{3, 8'h13, 1});
    sb_q.push_back('{0, 8'h10, 1});
    sb_q.push_back('{1, 8'h11, 2});
    for (int i = 0; i < 5; i++) serve_one();
    req_valid = '0;
    for (int r = 0; r < N; r++) reload_a[r] = 1'b0;
    tick();
    check_eq("clear_grant", grant, 0);

    // Zero-length message.
    setup_req(2, 8'h2C, 0, 1'b0, 1'b1);
    serve_one();

    // Length clamp.
    setup_req(1, 8'hC1, 255, 1'b0, 1'b1);
    serve_one();

    // Reset in the middle of a message from requester 0.
    setup_req(0, 8'h5A, 4, 1'b0, 1'b1);
    for (int w = 0; w < 60 && grant == '0; w++) tick();
    e = sb_q.pop_front();
    check_eq("mid_grant", grant, 1 << e.r);
    for (int k = 0; k < 2; k++) begin
      msgTrigger = 1'b1;
      tick();
      msgTrigger = 1'b0;
    end
    check_eq("mid_msglen", msgLen, 3);
    msgTrigger = 1'b1;
    rst        = 1'b1;
    req_valid  = '0;
    tick();
    rst        = 1'b0;
    msgTrigger = 1'b0;
    pidx[0]    = 0;
    check_eq("mid_rst_msg", msg, 0);
    check_eq("mid_rst_msglen", msgLen, 0);
    check_eq("mid_rst_grant", grant, 0);
    check_eq("mid_rst_pop", pay_pop, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_len_err", len_err, 0);
    tick();
    check_eq("post_rst_done", done, 0);
    check_eq("post_rst_grant", grant, 0);
    $display("reset mid-message abandoned req0");

    // Pointer back at 0: all four valid, requester 0 must win first.
    setup_req(0, 8'hA0, 1, 1'b0, 1'b1);
    setup_req(1, 8'hA1, 1, 1'b0, 1'b1);
    setup_req(2, 8'hA2, 1, 1'b0, 1'b1);
    setup_req(3, 8'hA3, 1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) serve_one();

    check_eq("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
